// File: rtl/ctrl_out_mux_gen_pkg.sv
// Shared definitions for the control-output multiplexer: config word layout, mode codes,
// fixed source codes and the per-channel FSM state type.
package ctrl_out_mux_gen_pkg;

  localparam int unsigned CfgSelLsb  = 0;
  localparam int unsigned CfgSelW    = 6;
  localparam int unsigned CfgInvBit  = 6;
  localparam int unsigned CfgModeLsb = 8;
  localparam int unsigned CfgDlyLsb  = 16;
  localparam int unsigned CfgDlyW    = 8;
  localparam int unsigned CfgWidLsb  = 24;
  localparam int unsigned CfgWidW    = 8;

  // The parent ties these source indices to constants.
  localparam int unsigned SrcLow  = 0;
  localparam int unsigned SrcHigh = 1;

  typedef enum logic [1:0] {
    ModeLevel  = 2'd0,
    ModeRise   = 2'd1,
    ModeFall   = 2'd2,
    ModeToggle = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StPulse
  } state_e;

  typedef struct packed {
    logic [CfgWidW-1:0] wid;
    logic [CfgDlyW-1:0] dly;
    mode_e              mode;
    logic               inv;
    logic [CfgSelW-1:0] sel;
  } cfg_t;

  function automatic cfg_t cfg_unpack(logic [31:0] w);
    cfg_t c;
    c.sel  = w[CfgSelLsb +: CfgSelW];
    c.inv  = w[CfgInvBit];
    c.mode = mode_e'(w[CfgModeLsb +: 2]);
    c.dly  = w[CfgDlyLsb +: CfgDlyW];
    c.wid  = w[CfgWidLsb +: CfgWidW];
    return c;
  endfunction

endpackage

// File: rtl/ctrl_out_mux_gen_if.sv
// Source, config and output bundle of the control-output multiplexer.
interface ctrl_out_mux_gen_if #(
  parameter int unsigned NumCh   = 8,
  parameter int unsigned SrcBits = 6
);
  localparam int unsigned NumSrc = 1 << SrcBits;
  localparam int unsigned AddrW  = (NumCh > 1) ? $clog2(NumCh) : 1;

  logic [NumSrc-1:0] src;
  logic              cfg_we;
  logic [AddrW-1:0]  cfg_addr;
  logic [31:0]       cfg_wdata;
  logic              cfg_update;
  logic [NumCh-1:0]  out;
  logic [NumCh-1:0]  busy;
  logic [NumCh-1:0]  missed;

  modport master (
    output src, cfg_we, cfg_addr, cfg_wdata, cfg_update,
    input  out, busy, missed
  );

  modport slave (
    input  src, cfg_we, cfg_addr, cfg_wdata, cfg_update,
    output out, busy, missed
  );
endinterface

// File: rtl/ctrl_out_mux_gen_chan.sv
// One output channel: shadow/active config, source mux with inversion, edge detect and
// the delay/pulse/toggle engine. SrcBits must not exceed the 6-bit select field.
module ctrl_out_mux_gen_chan
  import ctrl_out_mux_gen_pkg::*;
#(
  parameter int unsigned SrcBits = 6,
  parameter int unsigned DlyBits = 8,
  parameter int unsigned PlsBits = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [(1<<SrcBits)-1:0] src_i,
  input  logic                    we_i,
  input  logic [31:0]             wdata_i,
  input  logic                    update_i,
  output logic                    out_o,
  output logic                    busy_o,
  output logic                    missed_o
);

  cfg_t               shadow_q, shadow_d, active_q, cfg_sel;
  state_e             state_q;
  logic               s1_q, s1_d, s1d_q, supp_q, out_q, missed_q, trig;
  logic [DlyBits-1:0] dcnt_q, dly_ld;
  logic [PlsBits-1:0] pcnt_q, wid_ld;

  always_comb begin
    shadow_d = we_i ? cfg_unpack(wdata_i) : shadow_q;
    // On update the mux switches to the new selection in the same cycle.
    cfg_sel  = update_i ? shadow_d : active_q;
    s1_d     = src_i[cfg_sel.sel[SrcBits-1:0]] ^ cfg_sel.inv;
    dly_ld   = DlyBits'(active_q.dly);
    wid_ld   = (active_q.wid == '0) ? PlsBits'(1) : PlsBits'(active_q.wid);
    trig     = 1'b0;
    if (!supp_q) begin
      case (active_q.mode)
        ModeRise, ModeToggle: trig = s1_q & ~s1d_q;
        ModeFall:             trig = ~s1_q & s1d_q;
        default:              trig = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      state_q  <= StIdle;
      s1_q     <= 1'b0;
      s1d_q    <= 1'b0;
      supp_q   <= 1'b0;
      out_q    <= 1'b0;
      missed_q <= 1'b0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      s1_q     <= s1_d;
      if (update_i) begin
        active_q <= shadow_d;
        s1d_q    <= s1_d;
        supp_q   <= 1'b1;
        state_q  <= StIdle;
        out_q    <= 1'b0;
        missed_q <= 1'b0;
        dcnt_q   <= '0;
        pcnt_q   <= '0;
      end else begin
        s1d_q  <= s1_q;
        supp_q <= 1'b0;
        case (state_q)
          StIdle: begin
            if (active_q.mode == ModeLevel) begin
              out_q <= s1_q;
            end else if (trig) begin
              if (dly_ld != '0) begin
                state_q <= StDelay;
                dcnt_q  <= dly_ld;
              end else if (active_q.mode == ModeToggle) begin
                out_q <= ~out_q;
              end else begin
                state_q <= StPulse;
                out_q   <= 1'b1;
                pcnt_q  <= wid_ld;
              end
            end
          end
          StDelay: begin
            if (trig) missed_q <= 1'b1;
            if (dcnt_q <= DlyBits'(1)) begin
              dcnt_q <= '0;
              if (active_q.mode == ModeToggle) begin
                state_q <= StIdle;
                out_q   <= ~out_q;
              end else begin
                state_q <= StPulse;
                out_q   <= 1'b1;
                pcnt_q  <= wid_ld;
              end
            end else begin
              dcnt_q <= dcnt_q - DlyBits'(1);
            end
          end
          StPulse: begin
            if (trig) missed_q <= 1'b1;
            if (pcnt_q <= PlsBits'(1)) begin
              state_q <= StIdle;
              out_q   <= 1'b0;
              pcnt_q  <= '0;
            end else begin
              pcnt_q <= pcnt_q - PlsBits'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign out_o    = out_q;
  assign busy_o   = (state_q != StIdle);
  assign missed_o = missed_q;

endmodule

// File: rtl/ctrl_out_mux_gen.sv
// Control-output multiplexer top: config address decode and NumCh identical channels.
module ctrl_out_mux_gen
  import ctrl_out_mux_gen_pkg::*;
#(
  parameter int unsigned NumCh   = 8,
  parameter int unsigned SrcBits = 6,
  parameter int unsigned DlyBits = 8,
  parameter int unsigned PlsBits = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ctrl_out_mux_gen_if.slave   bus_io
);

  localparam int unsigned AddrW = (NumCh > 1) ? $clog2(NumCh) : 1;

  logic [NumCh-1:0] out_w, busy_w, missed_w;

  for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch
    logic we;
    // Addresses at or above NumCh match no channel and are dropped.
    assign we = bus_io.cfg_we && (bus_io.cfg_addr == AddrW'(gi));

    ctrl_out_mux_gen_chan #(
      .SrcBits (SrcBits),
      .DlyBits (DlyBits),
      .PlsBits (PlsBits)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .src_i    (bus_io.src),
      .we_i     (we),
      .wdata_i  (bus_io.cfg_wdata),
      .update_i (bus_io.cfg_update),
      .out_o    (out_w[gi]),
      .busy_o   (busy_w[gi]),
      .missed_o (missed_w[gi])
    );
  end

  assign bus_io.out    = out_w;
  assign bus_io.busy   = busy_w;
  assign bus_io.missed = missed_w;

endmodule
